// File: rtl/avst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// avst_rr_arbiter
//   Packet-aware round-robin arbiter that shares one Avalon-ST sink among
//   NUM_SRC sources. A source wins the grant on a start-of-packet beat and
//   keeps it until its end-of-packet beat is accepted, so packets from
//   different sources never interleave. The datapath is a zero-latency mux
//   of the granted source. The grant decision, busy and proto_err are
//   registered.
//
//   Optional feature macro: ARB_PKT_CNT_EN
//     defined   -> adds pkt_cnt, one 16-bit wrapping counter per source that
//                  counts accepted end-of-packet beats.
//     undefined -> no pkt_cnt port, no counters.
//
// Ports
//   clk        clock
//   rst_n      asynchronous reset, active low
//   src_data   source data, source i in [i*DW +: DW]
//   src_vld    per-source valid
//   src_sop    per-source start of packet
//   src_eop    per-source end of packet
//   src_empty  per-source empty byte count, source i in [i*EW +: EW]
//   src_rdy    per-source ready (only the owner can see ready)
//   snk_data   muxed data to the sink
//   snk_vld    muxed valid
//   snk_sop    muxed start of packet
//   snk_eop    muxed end of packet
//   snk_empty  muxed empty
//   snk_rdy    sink ready
//   grant      one-hot current owner, 0 when idle
//   busy       a packet is in progress
//   proto_err  one-cycle pulse: owner sent sop on a non-first beat
//   pkt_cnt    (ARB_PKT_CNT_EN only) per-source packet counters
// -----------------------------------------------------------------------------
module avst_rr_arbiter #(
    parameter int NUM_SRC             = 4,
    parameter int DATA_WIDTH_IN_BYTES = 1,
    localparam int DW = 8 * DATA_WIDTH_IN_BYTES,
    localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC*DW-1:0] src_data,
    input  logic [NUM_SRC-1:0]    src_vld,
    input  logic [NUM_SRC-1:0]    src_sop,
    input  logic [NUM_SRC-1:0]    src_eop,
    input  logic [NUM_SRC*EW-1:0] src_empty,
    output logic [NUM_SRC-1:0]    src_rdy,
    output logic [DW-1:0]         snk_data,
    output logic                  snk_vld,
    output logic                  snk_sop,
    output logic                  snk_eop,
    output logic [EW-1:0]         snk_empty,
    input  logic                  snk_rdy,
    output logic [NUM_SRC-1:0]    grant,
`ifdef ARB_PKT_CNT_EN
    output logic [NUM_SRC*16-1:0] pkt_cnt,
`endif
    output logic                  busy,
    output logic                  proto_err
);

    localparam int SW = $clog2(NUM_SRC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              state_r;
    logic [NUM_SRC-1:0]  grant_r;
    logic [SW-1:0]       owner_r;       // last / current owner index
    logic                busy_r;
    logic                first_beat_r;  // next accepted beat is the packet's first
    logic                proto_err_r;

    logic [NUM_SRC-1:0]  req_s;
    logic                pick_vld_s;
    logic [SW-1:0]       pick_idx_s;
    logic                xfer_s;

    // Only a valid start-of-packet beat counts as a request.
    assign req_s = src_vld & src_sop;

    // Round-robin pick: scan owner+1, owner+2, ... wrapping, first request wins.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_idx_s = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int  idx;
            logic hit;
            idx        = (int'(owner_r) + k) % NUM_SRC;
            hit        = req_s[idx] & ~pick_vld_s;
            pick_idx_s = hit ? SW'(idx) : pick_idx_s;
            pick_vld_s = pick_vld_s | hit;
        end
    end

    // Zero-latency datapath mux of the owner; ready/valid are gated while idle.
    always_comb begin
        snk_data  = src_data[int'(owner_r)*DW +: DW];
        snk_sop   = src_sop[owner_r];
        snk_eop   = src_eop[owner_r];
        snk_empty = src_empty[int'(owner_r)*EW +: EW];
        if (state_r == ST_BUSY) begin
            snk_vld = src_vld[owner_r];
            src_rdy = grant_r & {NUM_SRC{snk_rdy}};
        end else begin
            snk_vld = 1'b0;
            src_rdy = {NUM_SRC{1'b0}};
        end
    end

    assign xfer_s = snk_vld & snk_rdy;

    // Arbitration FSM: grant on a request in IDLE, release after the eop beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= {NUM_SRC{1'b0}};
            owner_r      <= SW'(NUM_SRC - 1);
            busy_r       <= 1'b0;
            first_beat_r <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            proto_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_r      <= ST_BUSY;
                        grant_r      <= {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx_s;
                        owner_r      <= pick_idx_s;
                        busy_r       <= 1'b1;
                        first_beat_r <= 1'b1;
                    end else begin
                        grant_r <= {NUM_SRC{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (xfer_s) begin
                        first_beat_r <= 1'b0;
                        // A second sop inside a packet is flagged but still forwarded.
                        proto_err_r  <= snk_sop & ~first_beat_r;
                        if (snk_eop) begin
                            state_r <= ST_IDLE;
                            grant_r <= {NUM_SRC{1'b0}};
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    grant_r      <= {NUM_SRC{1'b0}};
                    busy_r       <= 1'b0;
                    first_beat_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant     = grant_r;
    assign busy      = busy_r;
    assign proto_err = proto_err_r;

`ifdef ARB_PKT_CNT_EN
    logic [NUM_SRC*16-1:0] pkt_cnt_r;

    // Per-source packet counters, bumped on each accepted eop beat (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_r <= {(NUM_SRC*16){1'b0}};
        end else begin
            if (xfer_s && snk_eop) begin
                pkt_cnt_r[int'(owner_r)*16 +: 16] <= pkt_cnt_r[int'(owner_r)*16 +: 16] + 16'd1;
            end else begin
                pkt_cnt_r <= pkt_cnt_r;
            end
        end
    end

    assign pkt_cnt = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_avst_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_avst_rr_arbiter
//   Self-checking bench for avst_rr_arbiter (NUM_SRC=4, 1-byte beats).
//   Sources are driven from per-source beat queues that honour src_rdy; the
//   sink is either a forced ready, a depth-2 fifo model, or random ready.
// -----------------------------------------------------------------------------
module tb_avst_rr_arbiter;

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       e;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] src_data;
    logic [3:0]  src_vld;
    logic [3:0]  src_sop;
    logic [3:0]  src_eop;
    logic [3:0]  src_empty;
    logic [3:0]  src_rdy;
    logic [7:0]  snk_data;
    logic        snk_vld;
    logic        snk_sop;
    logic        snk_eop;
    logic [0:0]  snk_empty;
    logic        snk_rdy;
    logic [3:0]  grant;
    logic        busy;
    logic        proto_err;
`ifdef ARB_PKT_CNT_EN
    logic [63:0] pkt_cnt;
`endif

    int n_checks;
    int n_fail;

    // stimulus / sink state
    beat_t src_q [4][$];
    beat_t m_q   [4][$];
    logic [7:0] rx_q[$];
    logic [3:0] rx_g[$];
    logic       rx_sop[$];
    int         rx_c[$];
    int  cyc;
    bit  gap_en;
    int  sink_mode;   // 0 forced, 1 depth-2 fifo, 2 random
    bit  rdy_force;
    bit  rd_en;
    int  fifo_cnt;

    avst_rr_arbiter #(.NUM_SRC(4), .DATA_WIDTH_IN_BYTES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src_data  (src_data),
        .src_vld   (src_vld),
        .src_sop   (src_sop),
        .src_eop   (src_eop),
        .src_empty (src_empty),
        .src_rdy   (src_rdy),
        .snk_data  (snk_data),
        .snk_vld   (snk_vld),
        .snk_sop   (snk_sop),
        .snk_eop   (snk_eop),
        .snk_empty (snk_empty),
        .snk_rdy   (snk_rdy),
        .grant     (grant),
`ifdef ARB_PKT_CNT_EN
        .pkt_cnt   (pkt_cnt),
`endif
        .busy      (busy),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source drivers and sink model: sample at negedge, update just after posedge.
    initial begin
        logic [3:0] acc_v;
        bit         snk_acc;
        int         tmp;
        beat_t      b;
        forever begin
            @(negedge clk);
            acc_v   = src_vld & src_rdy;
            snk_acc = snk_vld & snk_rdy;
            if (snk_acc) begin
                rx_q.push_back(snk_data);
                rx_g.push_back(grant);
                rx_sop.push_back(snk_sop);
                rx_c.push_back(cyc);
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) fifo_cnt = 0;
            else begin
                tmp      = fifo_cnt;
                fifo_cnt = tmp + (snk_acc ? 1 : 0) - ((rd_en && tmp > 0) ? 1 : 0);
            end
            for (int i = 0; i < 4; i++) begin
                if (acc_v[i] && src_q[i].size() > 0) b = src_q[i].pop_front();
                if (src_q[i].size() > 0) begin
                    b = src_q[i][0];
                    src_data[i*8 +: 8] = b.d;
                    src_sop[i]   = b.sop;
                    src_eop[i]   = b.eop;
                    src_empty[i] = b.e;
                    if (src_vld[i] && !acc_v[i]) src_vld[i] = 1'b1;
                    else src_vld[i] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                end else begin
                    src_vld[i] = 1'b0;
                    src_sop[i] = 1'b0;
                    src_eop[i] = 1'b0;
                end
            end
            case (sink_mode)
                1:       snk_rdy = (fifo_cnt < 2);
                2:       snk_rdy = ($urandom_range(0, 3) != 0);
                default: snk_rdy = rdy_force;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            m_q[i].delete();
        end
        rx_q.delete(); rx_g.delete(); rx_sop.delete(); rx_c.delete();
        gap_en = 1'b0; sink_mode = 0; rdy_force = 1'b1; rd_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_pkt(input int s, input int len, input logic [7:0] base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + 8'(k); b.sop = (k == 0); b.eop = (k == len - 1); b.e = 1'b0;
            src_q[s].push_back(b);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_all();
        for (int i = 0; i < 4; i++) add_pkt(i, 1, 8'(16 * i));
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (src_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_src_rdy: got %b expected 0000", src_rdy); end
        if (snk_vld !== 1'b0) begin n_fail++; $display("FAIL reset_snk_vld: got %b expected 0", snk_vld); end
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 4;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL first_grant: got %b expected 0001", grant); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL first_busy: got %b expected 1", busy); end
        if (src_rdy !== 4'b0001) begin n_fail++; $display("FAIL first_src_rdy: got %b expected 0001", src_rdy); end
        if (snk_vld !== 1'b1 || snk_data !== 8'h00) begin
            n_fail++; $display("FAIL first_beat: got vld %b data %h expected 1 00", snk_vld, snk_data);
        end
        wait_rx(4, 40);
        n_checks++;
        if (rx_q.size() != 4) begin n_fail++; $display("FAIL reset_rx_count: got %0d expected 4", rx_q.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rx_q[i] !== 8'(16 * i)) begin n_fail++; $display("FAIL reset_rx_order[%0d]: got %h expected %h", i, rx_q[i], 8'(16 * i)); end
        end
    endtask

    task automatic test_rr_order();
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) add_pkt(i, 3, 8'(16 * i));
        wait_rx(24, 200);
        n_checks++;
        if (rx_q.size() != 24) begin n_fail++; $display("FAIL rr_rx_count: got %0d expected 24", rx_q.size()); end
        else for (int k = 0; k < 24; k++) begin
            int s;
            s = (k / 3) % 4;
            n_checks += 2;
            if (rx_q[k] !== 8'(16 * s + k % 3)) begin
                n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", k, rx_q[k], 8'(16 * s + k % 3));
            end
            if (rx_g[k] !== 4'(1 << s)) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, rx_g[k], 4'(1 << s));
            end
            if (k > 0) begin
                n_checks++;
                if (rx_c[k] - rx_c[k-1] != ((k % 3 == 0) ? 2 : 1)) begin
                    n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected %0d", k, rx_c[k] - rx_c[k-1], (k % 3 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int k = 0; k < 4; k++) add_pkt(2, 1, 8'(8'h20 + k));
        wait_rx(4, 40);
        @(negedge clk);
        n_checks += 2;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_final_grant: got %b expected 0000", grant); end
        if (rx_q.size() != 4) begin n_fail++; $display("FAIL single_rx_count: got %0d expected 4", rx_q.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks += 2;
            if (rx_g[k] !== 4'b0100 || rx_q[k] !== 8'(8'h20 + k)) begin
                n_fail++; $display("FAIL single_beat[%0d]: got grant %b data %h expected 0100 %h", k, rx_g[k], rx_q[k], 8'(8'h20 + k));
            end
            if (k > 0 && rx_c[k] - rx_c[k-1] != 2) begin
                n_fail++; $display("FAIL single_spacing[%0d]: got %0d expected 2", k, rx_c[k] - rx_c[k-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        sink_mode = 1;
        add_pkt(1, 4, 8'h00);
        repeat (12) @(negedge clk);
        n_checks += 4;
        if (rx_q.size() != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", rx_q.size()); end
        if (src_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_src_rdy: got %b expected 0000", src_rdy); end
        if (grant !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b expected 0010", grant); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %b expected 1", busy); end
        rd_en = 1'b1;
        wait_rx(4, 40);
        n_checks++;
        if (rx_q.size() != 4) begin n_fail++; $display("FAIL bp_rx_count: got %0d expected 4", rx_q.size()); end
        else for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rx_q[k] !== 8'(k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h expected %h", k, rx_q[k], 8'(k)); end
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        add_pkt(3, 4, 8'h30);
        wait_rx(2, 40);
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (grant !== 4'b0000) begin n_fail++; $display("FAIL midrst_grant: got %b expected 0000", grant); end
        if (snk_vld !== 1'b0) begin n_fail++; $display("FAIL midrst_snk_vld: got %b expected 0", snk_vld); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        src_q[3].delete();
        add_pkt(0, 1, 8'hA0);
        add_pkt(3, 1, 8'hB0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL midrst_regrant: got %b expected 0001", grant); end
        wait_rx(4, 40);
        n_checks++;
        if (rx_q.size() != 4) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 4", rx_q.size()); end
        else begin
            n_checks += 2;
            if (rx_q[1] !== 8'h31 || rx_q[2] !== 8'hA0) begin
                n_fail++; $display("FAIL midrst_seq_a: got %h %h expected 31 a0", rx_q[1], rx_q[2]);
            end
            if (rx_q[3] !== 8'hB0) begin n_fail++; $display("FAIL midrst_seq_b: got %h expected b0", rx_q[3]); end
        end
    endtask

    task automatic test_framing();
        beat_t b;
        int perr_cnt, bad_g;
        do_reset();
        add_pkt(0, 3, 8'h00);
        b = src_q[0][1]; b.sop = 1'b1; src_q[0][1] = b;
        b.d = 8'hEE; b.sop = 1'b0; b.eop = 1'b1; b.e = 1'b0;
        src_q[1].push_back(b);
        perr_cnt = 0; bad_g = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (proto_err === 1'b1) perr_cnt++;
            if (grant[1] !== 1'b0) bad_g++;
        end
        n_checks += 4;
        if (perr_cnt != 1) begin n_fail++; $display("FAIL frame_proto_err_cycles: got %0d expected 1", perr_cnt); end
        if (bad_g != 0) begin n_fail++; $display("FAIL frame_nosop_granted: got %0d cycles expected 0", bad_g); end
        if (src_q[1].size() != 1) begin n_fail++; $display("FAIL frame_nosop_accepted: queue %0d expected 1", src_q[1].size()); end
        if (rx_q.size() != 3) begin n_fail++; $display("FAIL frame_rx_count: got %0d expected 3", rx_q.size()); end
        else begin
            n_checks++;
            if (rx_q[1] !== 8'h01 || rx_sop[1] !== 1'b1) begin
                n_fail++; $display("FAIL frame_forwarded: got %h sop %b expected 01 1", rx_q[1], rx_sop[1]);
            end
        end
`ifdef ARB_PKT_CNT_EN
        n_checks++;
        if (pkt_cnt !== 64'h0000_0000_0000_0001) begin n_fail++; $display("FAIL frame_pkt_cnt: got %h expected 1", pkt_cnt); end
`endif
    endtask

    task automatic test_random();
        int m_owner, m_last, m_cnt[4];
        bit m_first, m_perr, done;
        logic [3:0] exp4, req;
        beat_t b;
        do_reset();
        gap_en = 1'b1;
        sink_mode = 2;
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            for (int p = 0; p < 6; p++) begin
                int len;
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++) begin
                    b.d   = 8'($urandom);
                    b.sop = (k == 0) || ($urandom_range(0, 7) == 0);
                    b.eop = (k == len - 1);
                    b.e   = 1'($urandom);
                    src_q[i].push_back(b);
                    m_q[i].push_back(b);
                end
            end
        end
        m_owner = -1; m_last = 3; m_first = 1'b0; m_perr = 1'b0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            exp4 = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            n_checks += 5;
            if (grant !== exp4) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", c, grant, exp4); end
            if (busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, m_owner >= 0); end
            if (proto_err !== m_perr) begin n_fail++; $display("FAIL rnd_proto_err c%0d: got %b expected %b", c, proto_err, m_perr); end
            if (src_rdy !== (snk_rdy ? exp4 : 4'b0000)) begin
                n_fail++; $display("FAIL rnd_src_rdy c%0d: got %b expected %b", c, src_rdy, snk_rdy ? exp4 : 4'b0000);
            end
            if (snk_vld !== ((m_owner >= 0) ? src_vld[m_owner] : 1'b0)) begin
                n_fail++; $display("FAIL rnd_snk_vld c%0d: got %b", c, snk_vld);
            end
            if (m_owner >= 0 && src_vld[m_owner] && m_q[m_owner].size() > 0) begin
                b = m_q[m_owner][0];
                n_checks++;
                if (snk_data !== b.d || snk_sop !== b.sop || snk_eop !== b.eop || snk_empty !== b.e) begin
                    n_fail++; $display("FAIL rnd_beat c%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", c,
                        snk_data, snk_sop, snk_eop, snk_empty, b.d, b.sop, b.eop, b.e);
                end
            end
            m_perr = 1'b0;
            if (m_owner < 0) begin
                req = src_vld & src_sop;
                for (int k = 1; k <= 4; k++) begin
                    int j;
                    j = (m_last + k) % 4;
                    if (req[j]) begin m_owner = j; m_last = j; m_first = 1'b1; break; end
                end
            end else if (src_vld[m_owner] && snk_rdy && m_q[m_owner].size() > 0) begin
                b = m_q[m_owner].pop_front();
                m_perr  = b.sop && !m_first;
                m_first = 1'b0;
                if (b.eop) begin m_cnt[m_owner]++; m_owner = -1; end
            end
            done = (m_owner < 0) && !m_perr && m_q[0].size() == 0 && m_q[1].size() == 0
                   && m_q[2].size() == 0 && m_q[3].size() == 0;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rnd_complete: packets left, owner %0d", m_owner); end
`ifdef ARB_PKT_CNT_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (pkt_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
                n_fail++; $display("FAIL rnd_pkt_cnt[%0d]: got %0d expected %0d", i, pkt_cnt[i*16 +: 16], m_cnt[i]);
            end
        end
`endif
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; fifo_cnt = 0;
        rst_n = 1'b0;
        src_data = 32'h0; src_vld = 4'h0; src_sop = 4'h0; src_eop = 4'h0; src_empty = 4'h0;
        snk_rdy = 1'b1;
        gap_en = 1'b0; sink_mode = 0; rdy_force = 1'b1; rd_en = 1'b0;
        test_reset();
        test_rr_order();
        test_single_beat();
        test_backpressure();
        test_reset_mid_packet();
        test_framing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
